// File: rtl/cnt_ctrl_pkg.sv
// Shared types for the modulo counter run controller: command opcodes and run states.
package cnt_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_START   = 3'd1,
    OP_STOP    = 3'd2,
    OP_PAUSE   = 3'd3,
    OP_RESUME  = 3'd4,
    OP_SET_MOD = 3'd5,
    OP_SET_DIR = 3'd6,
    OP_LOAD    = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

endpackage

// File: rtl/cnt_prescaler.sv
// Free-running step prescaler: emits a tick every PRESC_DIV enabled cycles and
// holds its phase while disabled, so a pause/resume keeps step timing.
module cnt_prescaler #(
  parameter int PRESC_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESC_DIV - 1);

  logic [PW-1:0] presc;

  assign tick = en && (presc == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      presc <= '0;
    else if (clr)   presc <= '0;
    else if (tick)  presc <= '0;
    else if (en)    presc <= presc + PW'(1'b1);
  end

endmodule

// File: rtl/cnt_run_ctrl.sv
// Run controller for the modulo LED counter: decodes valid/ready commands,
// sequences IDLE/RUN/PAUSE and steps an up/down modulo count on prescaled ticks.
module cnt_run_ctrl
  import cnt_ctrl_pkg::*;
#(
  parameter int WIDTH       = 3,
  parameter int PRESC_DIV   = 50_000_000,
  parameter int DEFAULT_MOD = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             wrap,
  output logic             err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             dir_q, dir_d;
  logic             wrap_d, err_d;
  logic             tick, presc_clr, accept;
  op_e              op;

  assign op        = op_e'(cmd_op);
  assign cmd_ready = !tick;
  assign accept    = cmd_valid && cmd_ready;

  cnt_prescaler #(.PRESC_DIV(PRESC_DIV)) u_presc (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == ST_RUN),
    .clr   (presc_clr),
    .tick  (tick)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    limit_d   = limit_q;
    dir_d     = dir_q;
    wrap_d    = 1'b0;
    err_d     = 1'b0;
    presc_clr = 1'b0;

    if (tick) begin
      // Commands are never accepted on a tick, so stepping owns the count here.
      if (!dir_q) begin
        wrap_d  = (count_q == limit_q);
        count_d = wrap_d ? '0 : count_q + WIDTH'(1'b1);
      end else begin
        wrap_d  = (count_q == '0);
        count_d = wrap_d ? limit_q : count_q - WIDTH'(1'b1);
      end
    end else if (accept) begin
      case (op)
        OP_NOP: ;
        OP_START: begin
          if (state_q == ST_IDLE) begin
            state_d   = ST_RUN;
            presc_clr = 1'b1;
          end else err_d = 1'b1;
        end
        OP_STOP: begin
          state_d   = ST_IDLE;
          count_d   = '0;
          presc_clr = 1'b1;
        end
        OP_PAUSE: begin
          if (state_q == ST_RUN)       state_d = ST_PAUSE;
          else if (state_q == ST_IDLE) err_d   = 1'b1;
        end
        OP_RESUME: begin
          if (state_q == ST_PAUSE) state_d = ST_RUN;
          else                     err_d   = 1'b1;
        end
        OP_SET_MOD: begin
          if (state_q == ST_RUN || cmd_arg == '0) err_d = 1'b1;
          else begin
            limit_d = cmd_arg;
            if (count_q > cmd_arg) count_d = '0;
          end
        end
        OP_SET_DIR: dir_d = cmd_arg[0];
        OP_LOAD: begin
          if (state_q == ST_RUN || cmd_arg > limit_q) err_d   = 1'b1;
          else                                        count_d = cmd_arg;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      limit_q <= WIDTH'(DEFAULT_MOD - 1);
      dir_q   <= 1'b0;
      wrap    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
      dir_q   <= dir_d;
      wrap    <= wrap_d;
      err     <= err_d;
    end
  end

  assign count = count_q;
  assign state = state_q;

endmodule

// File: tb/tb_cnt_run_ctrl.sv
// Randomised and directed bench for cnt_run_ctrl against an arithmetic
// reference model of the modulo counter and its run states.
module tb_cnt_run_ctrl;
  import cnt_ctrl_pkg::*;

  localparam int W    = 3;
  localparam int DIV  = 4;
  localparam int DMOD = 7;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_op = '0;
  logic [W-1:0] cmd_arg = '0;
  logic [W-1:0] count;
  logic [1:0]   state;
  logic         wrap, err;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: plain integers, modular arithmetic.
  int m_count, m_limit, m_dir, m_state, m_phase;
  bit m_wrap, m_err, m_ready, seen_ready;

  always #5 clk = ~clk;

  cnt_run_ctrl #(.WIDTH(W), .PRESC_DIV(DIV), .DEFAULT_MOD(DMOD)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .count     (count),
    .state     (state),
    .wrap      (wrap),
    .err       (err)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_count = 0; m_limit = DMOD - 1; m_dir = 0; m_state = 0; m_phase = 0;
    m_wrap = 0; m_err = 0;
  endtask

  task automatic model_edge(bit v, int op, int arg);
    bit tick;
    tick = (m_state == 1) && (m_phase == DIV - 1);
    m_wrap = 0;
    m_err  = 0;
    if (tick) begin
      m_phase = 0;
      if (m_dir == 0) begin
        m_wrap  = (m_count == m_limit);
        m_count = (m_count + 1) % (m_limit + 1);
      end else begin
        m_wrap  = (m_count == 0);
        m_count = (m_count + m_limit) % (m_limit + 1);
      end
    end else begin
      if (m_state == 1) m_phase++;
      if (v) begin
        case (op)
          1: if (m_state == 0) begin m_state = 1; m_phase = 0; end else m_err = 1;
          2: begin m_state = 0; m_count = 0; m_phase = 0; end
          3: if (m_state == 1) m_state = 2; else if (m_state == 0) m_err = 1;
          4: if (m_state == 2) m_state = 1; else m_err = 1;
          5: if (m_state == 1 || arg == 0) m_err = 1;
             else begin m_limit = arg; if (m_count > arg) m_count = 0; end
          6: m_dir = arg % 2;
          7: if (m_state == 1 || arg > m_limit) m_err = 1; else m_count = arg;
          default: ;
        endcase
      end
    end
  endtask

  // One clock: drive inputs, sample ready mid-cycle, advance model, land #1 after the edge.
  task automatic cycle(bit v, int op, int arg);
    cmd_valid = v;
    cmd_op    = 3'(op);
    cmd_arg   = W'(arg);
    @(negedge clk);
    seen_ready = cmd_ready;
    m_ready    = !((m_state == 1) && (m_phase == DIV - 1));
    model_edge(v, op, arg);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({cmd_ready, count, state, wrap, err} !== {1'b1, W'(0), 2'd0, 1'b0, 1'b0})
      $display("FAIL reset_state got rdy/cnt/st/wr/er=%b/%0d/%0d/%b/%b exp 1/0/0/0/0",
               cmd_ready, count, state, wrap, err);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic test_count_up();
    int nwrap = 0;
    cycle(1, OP_START, 0);
    for (int i = 1; i <= 7 * DIV; i++) begin
      cycle(0, OP_NOP, 0);
      if (wrap) nwrap++;
      n_checks++;
      if ({seen_ready, count, state, wrap, err} !== {m_ready, W'(m_count), 2'(m_state), m_wrap, m_err})
        $display("FAIL count_up_model cyc %0d got %b/%0d/%0d/%b/%b exp %b/%0d/%0d/%b/%b", i,
                 seen_ready, count, state, wrap, err, m_ready, m_count, m_state, m_wrap, m_err);
      else n_pass++;
      n_checks++;
      if (count !== W'((i / DIV) % DMOD))
        $display("FAIL count_up_seq cyc %0d got %0d exp %0d", i, count, (i / DIV) % DMOD);
      else n_pass++;
    end
    n_checks++;
    if (nwrap !== 1 || wrap !== 1'b1 || count !== '0)
      $display("FAIL count_up_wrap got wraps=%0d last_wrap=%b count=%0d exp 1/1/0", nwrap, wrap, count);
    else n_pass++;
  endtask

  task automatic test_direction();
    for (int i = 0; i < 2 * DIV; i++) cycle(0, OP_NOP, 0);
    n_checks++;
    if (count !== W'(2)) $display("FAIL dir_start got %0d exp 2", count);
    else n_pass++;
    cycle(1, OP_SET_DIR, 1);
    for (int i = 1; i < 3 * DIV; i++) begin
      cycle(0, OP_NOP, 0);
      n_checks++;
      if ({seen_ready, count, state, wrap, err} !== {m_ready, W'(m_count), 2'(m_state), m_wrap, m_err})
        $display("FAIL dir_model cyc %0d got %b/%0d/%0d/%b/%b exp %b/%0d/%0d/%b/%b", i,
                 seen_ready, count, state, wrap, err, m_ready, m_count, m_state, m_wrap, m_err);
      else n_pass++;
    end
    n_checks++;
    if (count !== W'(6) || wrap !== 1'b1)
      $display("FAIL dir_down_wrap got count=%0d wrap=%b exp 6/1", count, wrap);
    else n_pass++;
  endtask

  task automatic test_pause_resume();
    cycle(0, OP_NOP, 0);
    cycle(1, OP_PAUSE, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, OP_NOP, 0);
      n_checks++;
      if (count !== W'(6) || state !== 2'd2 || cmd_ready !== 1'b1)
        $display("FAIL pause_hold cyc %0d got count=%0d state=%0d rdy=%b exp 6/2/1", i, count, state, cmd_ready);
      else n_pass++;
    end
    cycle(1, OP_RESUME, 0);
    cycle(0, OP_NOP, 0);
    n_checks++;
    if (count !== W'(6) || state !== 2'd1)
      $display("FAIL resume_early got count=%0d state=%0d exp 6/1", count, state);
    else n_pass++;
    cycle(0, OP_NOP, 0);
    n_checks++;
    if (count !== W'(5)) $display("FAIL resume_step got %0d exp 5", count);
    else n_pass++;
  endtask

  task automatic test_set_mod_load();
    cycle(1, OP_SET_MOD, 2);
    n_checks++;
    if (err !== 1'b1 || count !== W'(5) || state !== 2'd1)
      $display("FAIL setmod_run got err=%b count=%0d state=%0d exp 1/5/1", err, count, state);
    else n_pass++;
    cycle(1, OP_SET_DIR, 0);
    cycle(1, OP_STOP, 0);
    n_checks++;
    if (count !== '0 || state !== 2'd0 || err !== 1'b0)
      $display("FAIL stop got count=%0d state=%0d err=%b exp 0/0/0", count, state, err);
    else n_pass++;
    cycle(1, OP_LOAD, 5);
    cycle(1, OP_SET_MOD, 2);
    n_checks++;
    if (count !== '0 || err !== 1'b0)
      $display("FAIL setmod_shrink got count=%0d err=%b exp 0/0", count, err);
    else n_pass++;
    cycle(1, OP_START, 0);
    for (int i = 1; i <= 3 * DIV; i++) begin
      cycle(0, OP_NOP, 0);
      n_checks++;
      if (count !== W'((i / DIV) % 3) || wrap !== (i == 3 * DIV))
        $display("FAIL mod3_seq cyc %0d got count=%0d wrap=%b exp %0d/%b", i, count, wrap,
                 (i / DIV) % 3, (i == 3 * DIV));
      else n_pass++;
    end
  endtask

  task automatic test_load_err();
    cycle(1, OP_STOP, 0);
    cycle(1, OP_SET_MOD, 6);
    cycle(1, OP_LOAD, 7);
    n_checks++;
    if (err !== 1'b1 || count !== '0)
      $display("FAIL load_over got err=%b count=%0d exp 1/0", err, count);
    else n_pass++;
    cycle(1, OP_START, 0);
    for (int i = 0; i < DIV + 1; i++) cycle(0, OP_NOP, 0);
    cycle(1, OP_PAUSE, 0);
    cycle(1, OP_LOAD, 4);
    n_checks++;
    if (count !== W'(4) || err !== 1'b0 || state !== 2'd2)
      $display("FAIL load_pause got count=%0d err=%b state=%0d exp 4/0/2", count, err, state);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int budget = 0;
    cycle(1, OP_RESUME, 0);
    while (m_count != 5 && budget < 40) begin
      cycle(0, OP_NOP, 0);
      budget++;
    end
    n_checks++;
    if (count !== W'(5)) $display("FAIL reach_five got %0d exp 5 after %0d cycles", count, budget);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({count, state, wrap, err} !== {W'(0), 2'd0, 1'b0, 1'b0})
      $display("FAIL reset_mid got count=%0d state=%0d wrap=%b err=%b exp 0/0/0/0", count, state, wrap, err);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    cycle(1, OP_LOAD, 7);
    n_checks++;
    if (err !== 1'b1) $display("FAIL reset_limit_hi got err=%b exp 1", err);
    else n_pass++;
    cycle(1, OP_LOAD, 6);
    n_checks++;
    if (err !== 1'b0 || count !== W'(6)) $display("FAIL reset_limit_lo got err=%b count=%0d exp 0/6", err, count);
    else n_pass++;
    cycle(1, OP_START, 0);
    for (int i = 0; i < DIV; i++) cycle(0, OP_NOP, 0);
    n_checks++;
    if (count !== '0 || wrap !== 1'b1) $display("FAIL reset_dir_up got count=%0d wrap=%b exp 0/1", count, wrap);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 2) == 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      n_checks++;
      if ({seen_ready, count, state, wrap, err} !== {m_ready, W'(m_count), 2'(m_state), m_wrap, m_err})
        $display("FAIL random cyc %0d got %b/%0d/%0d/%b/%b exp %b/%0d/%0d/%b/%b", i,
                 seen_ready, count, state, wrap, err, m_ready, m_count, m_state, m_wrap, m_err);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_direction();
    test_pause_resume();
    test_set_mod_load();
    test_load_err();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
